ahb_master_arbiter: RTL

Sequences the core's single AHB-Lite master port between two requesters: instruction fetch (IF) and load/store (LSU).
- Issues pipelined NONSEQ address phases and tracks the one outstanding data phase.
- Drives muxsel so the glue logic steers hr_data to instruction (muxsel=0) or mem_out (muxsel=1).
- Handles wait states, two-cycle ERROR responses and fetch starvation.

---
 rtl/ahb_master_arbiter_pkg.sv | 30 +++
 rtl/ahb_master_arbiter_req.sv | 46 ++++
 rtl/ahb_master_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ahb_master_arbiter_pkg.sv
// Shared AHB-Lite types and constants for the master-port arbiter.
// Holds htrans/hsize/hprot encodings, data-phase owner and FSM state enums.
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [3:0] HPROT_FETCH = 4'b0000;
    localparam logic [3:0] HPROT_DATA  = 4'b0001;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_ERR1 = 2'b10
    } arb_state_t;

endpackage

// File: rtl/ahb_master_arbiter_req.sv
// Fixed-priority IF/LSU select with fetch-starvation counter.
// Ports: clk, reset, if_req, d_req, gnt_fire in; sel_valid, sel, burst_cnt out.
module ahb_req_arbiter
    import ahb_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 if_req,
    input  logic                                 d_req,
    input  logic                                 gnt_fire,
    output logic                                 sel_valid,
    output owner_t                               sel,
    output logic [$clog2(MAX_DATA_BURST+1)-1:0]  burst_cnt
);

    localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_BURST);

    logic starve;

    // LSU wins unless it already took CNT_MAX grants while fetch waited.
    assign starve = if_req && (burst_cnt == CNT_MAX);

    always_comb begin
        sel_valid = if_req || d_req;
        sel       = OWN_IF;
        if (d_req && !starve) begin
            sel = OWN_LSU;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (!if_req) begin
            burst_cnt <= '0;
        end else if (gnt_fire && sel == OWN_IF) begin
            burst_cnt <= '0;
        end else if (gnt_fire && burst_cnt != CNT_MAX) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// AHB-Lite single-master sequencer for fetch (IF) and load/store (LSU).
// Ports: IF/LSU req-gnt-rvalid, AHB master signals, muxsel, bus_timeout.
// Option: define AHB_ARB_TIMEOUT_EN to abort data phases stuck at hready=0.
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_size,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [1:0]        htrans,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [3:0]        hprot,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp,
    output logic              muxsel,
    output logic              bus_timeout
);

    localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);

    arb_state_t       state, state_nxt;
    owner_t           owner, sel;
    logic             sel_valid;
    logic [CNT_W-1:0] burst_cnt;
    logic             issue_ok, gnt_fire;
    logic             done_ok, err_done, to_hit;
    logic             rvalid, err;
    logic [DATA_W-1:0] rdata;

    ahb_req_arbiter #(
        .MAX_DATA_BURST(MAX_DATA_BURST)
    ) u_req_arb (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .d_req    (d_req),
        .gnt_fire (gnt_fire),
        .sel_valid(sel_valid),
        .sel      (sel),
        .burst_cnt(burst_cnt)
    );

    // Pipelined issue: only when the current data phase finishes cleanly.
    assign issue_ok = !reset && !hresp &&
                      (state == ST_IDLE || (state == ST_DATA && hready));
    assign gnt_fire = issue_ok && sel_valid;
    assign done_ok  = (state == ST_DATA) && hready && !hresp;
    // ERR1 closes on hready regardless of hresp so a glitchy slave cannot hang us.
    assign err_done = ((state == ST_DATA) && hready && hresp) ||
                      ((state == ST_ERR1) && hready);

`ifdef AHB_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_flag;
    logic            stalled;

    assign stalled = (state != ST_IDLE) && !hready;
    assign to_hit  = stalled && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            to_cnt <= (stalled && !to_hit) ? to_cnt + 1'b1 : '0;
            if (to_hit) begin
                to_flag <= 1'b1;
            end
        end
    end

    assign bus_timeout = to_flag;
`else
    assign to_hit      = 1'b0;
    assign bus_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner  <= OWN_IF;
            hwdata <= '0;
        end else if (gnt_fire) begin
            owner <= sel;
            if (sel == OWN_LSU && d_we) begin
                hwdata <= d_wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (gnt_fire) state_nxt = ST_DATA;
            ST_DATA: begin
                if (to_hit)                state_nxt = ST_IDLE;
                else if (hresp && !hready) state_nxt = ST_ERR1;
                else if (hresp)            state_nxt = ST_IDLE;
                else if (hready)           state_nxt = gnt_fire ? ST_DATA : ST_IDLE;
            end
            ST_ERR1: if (to_hit || hready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        htrans = HT_IDLE;
        haddr  = '0;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        hprot  = HPROT_FETCH;
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (gnt_fire) begin
            htrans = HT_NONSEQ;
            if (sel == OWN_LSU) begin
                haddr  = d_addr;
                hwrite = d_we;
                hsize  = d_size;
                hprot  = HPROT_DATA;
                d_gnt  = 1'b1;
            end else begin
                haddr  = if_addr;
                if_gnt = 1'b1;
            end
        end
        rvalid    = done_ok || err_done || to_hit;
        err       = err_done || to_hit;
        rdata     = (rvalid && !to_hit) ? hrdata : '0;
        if_rvalid = rvalid && (owner == OWN_IF);
        d_rvalid  = rvalid && (owner == OWN_LSU);
        if_err    = err && (owner == OWN_IF);
        d_err     = err && (owner == OWN_LSU);
        if_rdata  = if_rvalid ? rdata : '0;
        d_rdata   = d_rvalid ? rdata : '0;
    end

    assign muxsel = owner;

    // Starvation counter must saturate, never wrap past the burst limit.
    a_burst_sat: assert property (@(posedge clk) disable iff (reset)
        burst_cnt <= CNT_W'(MAX_DATA_BURST));

endmodule
